// File: rtl/trig_updown_counter.sv
// Host-triggered 32-bit up/down counter with free-run divider,
// optional saturation, coherent snapshot and sticky wrap status.
module trig_updown_counter #(
    parameter int              WIDTH     = 32,
    parameter int              DIV_W     = 24,
    parameter logic [DIV_W-1:0] DIV_RESET = 24'd1000000
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic [7:0]       trig,
    input  logic [WIDTH-1:0] load_value,
    input  logic [15:0]      step,
    input  logic [DIV_W-1:0] div_value,
    input  logic             sat_mode,
    input  logic             status_clr,
    output logic [WIDTH-1:0] count,
    output logic [15:0]      snap_lo,
    output logic [15:0]      snap_hi,
    output logic [15:0]      status,
    output logic             evt_wrap
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DIV_W-1:0]   r_div_per;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]   r_snap;
    logic               r_wrap_up;
    logic               r_wrap_dn;
    logic               r_sat_hit;
    logic               r_evt;

    logic               w_enter;
    logic               w_tick;
    logic [WIDTH-1:0]   w_s;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_cnt_nxt;
    logic               w_up;
    logic               w_dn;
    logic               w_evt;
    logic               w_set_wu;
    logic               w_set_wd;
    logic               w_set_sat;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (trig[5])      w_state_nxt = RUN_UP;
                else if (trig[6]) w_state_nxt = RUN_DOWN;
            end
            RUN_UP: begin
                if (trig[7] || trig[0]) w_state_nxt = IDLE;
                else if (trig[6])       w_state_nxt = RUN_DOWN;
            end
            RUN_DOWN: begin
                if (trig[7] || trig[0]) w_state_nxt = IDLE;
                else if (trig[5])       w_state_nxt = RUN_UP;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Any transition into a run state (including a direction switch) restarts the divider
    assign w_enter = (w_state_nxt != IDLE) && (w_state_nxt != r_state);
    assign w_tick  = (r_state != IDLE) && (r_div_cnt == r_div_per);

    always_ff @(posedge clk1) begin
        if (reset) begin
            r_div_per <= DIV_RESET;
            r_div_cnt <= '0;
        end else if (w_enter) begin
            r_div_per <= div_value;
            r_div_cnt <= '0;
        end else if (w_state_nxt == IDLE || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign w_s    = (step == 16'd0) ? WIDTH'(1) : {{(WIDTH-16){1'b0}}, step};
    assign w_sum  = {1'b0, r_count} + {1'b0, w_s};
    assign w_diff = {1'b0, r_count} - {1'b0, w_s};

    always_comb begin
        w_cnt_nxt = r_count;
        w_up      = 1'b0;
        w_dn      = 1'b0;
        w_evt     = 1'b0;
        w_set_wu  = 1'b0;
        w_set_wd  = 1'b0;
        w_set_sat = 1'b0;
        if (trig[0]) begin
            w_cnt_nxt = '0;
        end else if (trig[3]) begin
            w_cnt_nxt = load_value;
        end else if (trig[1] && trig[2]) begin
            w_cnt_nxt = r_count;
        end else if (trig[1]) begin
            w_up = 1'b1;
        end else if (trig[2]) begin
            w_dn = 1'b1;
        end else if (w_tick) begin
            w_up = (r_state == RUN_UP);
            w_dn = (r_state == RUN_DOWN);
        end
        if (w_up) begin
            w_cnt_nxt = w_sum[WIDTH-1:0];
            if (w_sum[WIDTH]) begin
                w_evt = 1'b1;
                if (sat_mode) begin
                    w_cnt_nxt = '1;
                    w_set_sat = 1'b1;
                end else begin
                    w_set_wu = 1'b1;
                end
            end
        end
        if (w_dn) begin
            w_cnt_nxt = w_diff[WIDTH-1:0];
            if (w_diff[WIDTH]) begin
                w_evt = 1'b1;
                if (sat_mode) begin
                    w_cnt_nxt = '0;
                    w_set_sat = 1'b1;
                end else begin
                    w_set_wd = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            r_count   <= '0;
            r_snap    <= '0;
            r_evt     <= 1'b0;
            r_wrap_up <= 1'b0;
            r_wrap_dn <= 1'b0;
            r_sat_hit <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            r_evt   <= w_evt;
            if (trig[4]) r_snap <= r_count;
            // A new event outranks a simultaneous clear request
            r_wrap_up <= w_set_wu  | (r_wrap_up & ~status_clr);
            r_wrap_dn <= w_set_wd  | (r_wrap_dn & ~status_clr);
            r_sat_hit <= w_set_sat | (r_sat_hit & ~status_clr);
        end
    end

    assign count    = r_count;
    assign snap_lo  = r_snap[15:0];
    assign snap_hi  = r_snap[31:16];
    assign evt_wrap = r_evt;
    assign status   = {11'd0, (r_state == RUN_DOWN), (r_state != IDLE),
                       r_sat_hit, r_wrap_dn, r_wrap_up};

endmodule

// File: tb/tb_trig_updown_counter.sv
// Directed bench for trig_updown_counter: vector table plus
// hand-written run, tick-drop, saturation and reset sequences.
module tb_trig_updown_counter;

    logic        clk1 = 1'b0;
    logic        reset;
    logic [7:0]  trig;
    logic [31:0] load_value;
    logic [15:0] step;
    logic [23:0] div_value;
    logic        sat_mode;
    logic        status_clr;
    logic [31:0] count;
    logic [15:0] snap_lo;
    logic [15:0] snap_hi;
    logic [15:0] status;
    logic        evt_wrap;

    int n_chk  = 0;
    int n_fail = 0;

    trig_updown_counter dut (
        .clk1       (clk1),
        .reset      (reset),
        .trig       (trig),
        .load_value (load_value),
        .step       (step),
        .div_value  (div_value),
        .sat_mode   (sat_mode),
        .status_clr (status_clr),
        .count      (count),
        .snap_lo    (snap_lo),
        .snap_hi    (snap_hi),
        .status     (status),
        .evt_wrap   (evt_wrap)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [7:0]  trig;
        logic [31:0] ld;
        logic [15:0] step;
        logic        sat;
        logic        sclr;
        logic [31:0] e_cnt;
        logic [31:0] e_snap;
        logic [15:0] e_st;
        logic        e_evt;
    } vec_t;

    vec_t vt[19];

    task automatic cyc();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vt[0]  = '{8'h02, 32'h0,         16'd0, 1'b0, 1'b0, 32'd1,         32'h0,         16'h0, 1'b0};
        vt[1]  = '{8'h02, 32'h0,         16'd0, 1'b0, 1'b0, 32'd2,         32'h0,         16'h0, 1'b0};
        vt[2]  = '{8'h02, 32'h0,         16'd0, 1'b0, 1'b0, 32'd3,         32'h0,         16'h0, 1'b0};
        vt[3]  = '{8'h08, 32'hFFFFFFFE,  16'd4, 1'b0, 1'b0, 32'hFFFFFFFE,  32'h0,         16'h0, 1'b0};
        vt[4]  = '{8'h02, 32'h0,         16'd4, 1'b0, 1'b0, 32'd2,         32'h0,         16'h1, 1'b1};
        vt[5]  = '{8'h00, 32'h0,         16'd4, 1'b0, 1'b0, 32'd2,         32'h0,         16'h1, 1'b0};
        vt[6]  = '{8'h00, 32'h0,         16'd4, 1'b0, 1'b1, 32'd2,         32'h0,         16'h0, 1'b0};
        vt[7]  = '{8'h08, 32'hFFFFFFFE,  16'd4, 1'b1, 1'b0, 32'hFFFFFFFE,  32'h0,         16'h0, 1'b0};
        vt[8]  = '{8'h02, 32'h0,         16'd4, 1'b1, 1'b0, 32'hFFFFFFFF,  32'h0,         16'h4, 1'b1};
        vt[9]  = '{8'h06, 32'h0,         16'd4, 1'b1, 1'b0, 32'hFFFFFFFF,  32'h0,         16'h4, 1'b0};
        vt[10] = '{8'h00, 32'h0,         16'd4, 1'b1, 1'b1, 32'hFFFFFFFF,  32'h0,         16'h0, 1'b0};
        vt[11] = '{8'h01, 32'h0,         16'd0, 1'b0, 1'b0, 32'd0,         32'h0,         16'h0, 1'b0};
        vt[12] = '{8'h04, 32'h0,         16'd0, 1'b0, 1'b1, 32'hFFFFFFFF,  32'h0,         16'h2, 1'b1};
        vt[13] = '{8'h00, 32'h0,         16'd0, 1'b0, 1'b1, 32'hFFFFFFFF,  32'h0,         16'h0, 1'b0};
        vt[14] = '{8'h08, 32'h0001FFFF,  16'd1, 1'b0, 1'b0, 32'h0001FFFF,  32'h0,         16'h0, 1'b0};
        vt[15] = '{8'h12, 32'h0,         16'd1, 1'b0, 1'b0, 32'h00020000,  32'h0001FFFF,  16'h0, 1'b0};
        vt[16] = '{8'h11, 32'h0,         16'd1, 1'b0, 1'b0, 32'd0,         32'h00020000,  16'h0, 1'b0};
        vt[17] = '{8'h04, 32'h0,         16'd1, 1'b1, 1'b0, 32'd0,         32'h00020000,  16'h4, 1'b1};
        vt[18] = '{8'h00, 32'h0,         16'd1, 1'b0, 1'b1, 32'd0,         32'h00020000,  16'h0, 1'b0};

        reset      = 1'b1;
        trig       = 8'h00;
        load_value = 32'h0;
        step       = 16'd0;
        div_value  = 24'd3;
        sat_mode   = 1'b0;
        status_clr = 1'b0;
        cyc();
        cyc();
        chk("rst_count",  count,    32'h0);
        chk("rst_snap",   {snap_hi, snap_lo}, 32'h0);
        chk("rst_status", 32'(status), 32'h0);
        chk("rst_evt",    32'(evt_wrap), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            trig       = vt[i].trig;
            load_value = vt[i].ld;
            step       = vt[i].step;
            sat_mode   = vt[i].sat;
            status_clr = vt[i].sclr;
            cyc();
            chk($sformatf("v%0d_count", i),  count, vt[i].e_cnt);
            chk($sformatf("v%0d_snap", i),   {snap_hi, snap_lo}, vt[i].e_snap);
            chk($sformatf("v%0d_status", i), 32'(status), 32'(vt[i].e_st));
            chk($sformatf("v%0d_evt", i),    32'(evt_wrap), 32'(vt[i].e_evt));
        end
        trig       = 8'h00;
        status_clr = 1'b0;
        sat_mode   = 1'b0;
        step       = 16'd1;

        // free run up, period 4
        div_value = 24'd3;
        trig = 8'h20;
        cyc();
        chk("run_status", 32'(status), 32'h8);
        trig = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (k == 3)  chk("run_k3",  count, 32'd0);
            if (k == 4)  chk("run_k4",  count, 32'd1);
            if (k == 7)  chk("run_k7",  count, 32'd1);
            if (k == 8)  chk("run_k8",  count, 32'd2);
            if (k == 20) chk("run_k20", count, 32'd5);
        end
        trig = 8'h80;
        cyc();
        chk("stop_count",  count, 32'd5);
        chk("stop_status", 32'(status), 32'h0);
        trig = 8'h00;
        repeat (6) cyc();
        chk("frozen_count", count, 32'd5);

        // manual down coincident with a tick: tick dropped
        trig = 8'h20;
        cyc();
        trig = 8'h00;
        repeat (3) cyc();
        trig = 8'h04;
        cyc();
        chk("drop_e4", count, 32'd4);
        trig = 8'h00;
        repeat (3) cyc();
        chk("drop_e7", count, 32'd4);
        cyc();
        chk("drop_e8", count, 32'd5);
        trig = 8'h80;
        cyc();
        trig = 8'h00;

        // saturated run re-pulses evt_wrap on every tick
        load_value = 32'hFFFFFFFF;
        trig = 8'h08;
        cyc();
        sat_mode  = 1'b1;
        div_value = 24'd0;
        trig = 8'h20;
        cyc();
        chk("satrun_entry_evt", 32'(evt_wrap), 32'h0);
        trig = 8'h00;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("satrun%0d_count", k),  count, 32'hFFFFFFFF);
            chk($sformatf("satrun%0d_evt", k),    32'(evt_wrap), 32'h1);
            chk($sformatf("satrun%0d_status", k), 32'(status), 32'hC);
        end
        trig = 8'h80;
        cyc();
        chk("satstop_status", 32'(status), 32'h4);
        trig = 8'h00;
        status_clr = 1'b1;
        cyc();
        status_clr = 1'b0;
        sat_mode   = 1'b0;
        chk("satclr_status", 32'(status), 32'h0);

        // reset in RUN_DOWN with a tick pending
        load_value = 32'd5;
        trig = 8'h08;
        cyc();
        div_value = 24'd3;
        trig = 8'h40;
        cyc();
        chk("rdn_status", 32'(status), 32'h18);
        trig = 8'h00;
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        chk("midrst_count",  count, 32'h0);
        chk("midrst_status", 32'(status), 32'h0);
        chk("midrst_evt",    32'(evt_wrap), 32'h0);
        reset = 1'b0;
        cyc();
        chk("postrst_count",  count, 32'h0);
        chk("postrst_status", 32'(status), 32'h0);
        chk("postrst_evt",    32'(evt_wrap), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
